// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC bus arbiter: FSM states, idle strobe
// pattern, default bus timing and the RTC register map.
package rtc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_HOLD,
    S_DATA,
    S_REC,
    S_DONE
  } state_e;

  // Strobe order is {cs_n, as_n, rd_n, wr_n}; all deasserted.
  localparam logic [3:0] STROBE_IDLE = 4'b1111;

  localparam int DEF_T_ADDR = 4;
  localparam int DEF_T_HOLD = 2;
  localparam int DEF_T_DATA = 6;
  localparam int DEF_T_REC  = 2;

  localparam logic [7:0] RTC_SEC   = 8'h00;
  localparam logic [7:0] RTC_MIN   = 8'h02;
  localparam logic [7:0] RTC_HOUR  = 8'h04;
  localparam logic [7:0] RTC_DOW   = 8'h06;
  localparam logic [7:0] RTC_DATE  = 8'h07;
  localparam logic [7:0] RTC_MONTH = 8'h08;
  localparam logic [7:0] RTC_YEAR  = 8'h09;
  localparam logic [7:0] RTC_REG_A = 8'h0A;
  localparam logic [7:0] RTC_REG_B = 8'h0B;
  localparam logic [7:0] RTC_REG_C = 8'h0C;
  localparam logic [7:0] RTC_REG_D = 8'h0D;

  // Terminal count of the 6-bit phase counter for a phase of len cycles.
  function automatic logic [5:0] phaseLast(input int len);
    return 6'(len - 1);
  endfunction

endpackage

// File: rtl/rtc_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot winner among req_i, searching
// upward from the requester after last_i and wrapping around.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_i) + k) % N_REQ;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter sharing the RTC multiplexed address/data bus; runs one
// strobed ADDR/HOLD/DATA/REC transaction per grant with registered pin outputs.
module rtc_bus_arbiter
  import rtc_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int T_ADDR = DEF_T_ADDR,
  parameter int T_HOLD = DEF_T_HOLD,
  parameter int T_DATA = DEF_T_DATA,
  parameter int T_REC  = DEF_T_REC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     we,
  input  logic [8*N_REQ-1:0]   addr,
  input  logic [8*N_REQ-1:0]   wdata,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic [7:0]           rdata,
  output logic                 cs_n,
  output logic                 as_n,
  output logic                 rd_n,
  output logic                 wr_n,
  output logic [7:0]           ad_out,
  output logic                 ad_oe,
  input  logic [7:0]           ad_in
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [5:0] LAST_ADDR = phaseLast(T_ADDR);
  localparam logic [5:0] LAST_HOLD = phaseLast(T_HOLD);
  localparam logic [5:0] LAST_DATA = phaseLast(T_DATA);
  localparam logic [5:0] LAST_REC  = phaseLast(T_REC);

  state_e             state_q;
  logic [5:0]         cnt_q;
  logic [IDX_W-1:0]   winIdx_q;
  logic [IDX_W-1:0]   lastWin_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   done_q;
  logic               weL_q;
  logic [7:0]         wdataL_q;
  logic [7:0]         capt_q;
  logic [7:0]         rdata_q;
  logic               csN_q;
  logic               asN_q;
  logic               rdN_q;
  logic               wrN_q;
  logic [7:0]         adOut_q;
  logic               adOe_q;

  logic [N_REQ-1:0]   pickOh;
  logic [IDX_W-1:0]   pickIdx;
  logic               anyReq;

  rr_picker #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) uPicker (
    .req_i (req),
    .last_i(lastWin_q),
    .gnt_o (pickOh),
    .idx_o (pickIdx),
    .any_o (anyReq)
  );

  // Each transition sets the pin values for the state being entered, so the
  // strobes come straight from flops and change exactly on phase boundaries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q                      <= S_IDLE;
      cnt_q                        <= '0;
      winIdx_q                     <= '0;
      lastWin_q                    <= IDX_W'(N_REQ - 1);
      gnt_q                        <= '0;
      done_q                       <= '0;
      weL_q                        <= 1'b0;
      wdataL_q                     <= '0;
      capt_q                       <= '0;
      rdata_q                      <= '0;
      {csN_q, asN_q, rdN_q, wrN_q} <= STROBE_IDLE;
      adOut_q                      <= '0;
      adOe_q                       <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (anyReq) begin
            state_q  <= S_ADDR;
            gnt_q    <= pickOh;
            winIdx_q <= pickIdx;
            weL_q    <= we[pickIdx];
            wdataL_q <= wdata[8*pickIdx +: 8];
            asN_q    <= 1'b0;
            adOe_q   <= 1'b1;
            adOut_q  <= addr[8*pickIdx +: 8];
          end
        end
        S_ADDR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            asN_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_HOLD: begin
          if (cnt_q == LAST_HOLD) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            csN_q   <= 1'b0;
            if (weL_q) begin
              wrN_q   <= 1'b0;
              adOut_q <= wdataL_q;
            end else begin
              rdN_q   <= 1'b0;
              adOe_q  <= 1'b0;
              adOut_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == LAST_DATA) begin
            state_q                      <= S_REC;
            cnt_q                        <= '0;
            {csN_q, asN_q, rdN_q, wrN_q} <= STROBE_IDLE;
            adOe_q                       <= 1'b0;
            adOut_q                      <= '0;
            if (!weL_q) begin
              capt_q <= ad_in;
            end
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_REC: begin
          if (cnt_q == LAST_REC) begin
            state_q   <= S_DONE;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= gnt_q;
            lastWin_q <= winIdx_q;
            if (!weL_q) begin
              rdata_q <= capt_q;
            end
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign cs_n   = csN_q;
  assign as_n   = asN_q;
  assign rd_n   = rdN_q;
  assign wr_n   = wrN_q;
  assign ad_out = adOut_q;
  assign ad_oe  = adOe_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Scoreboard bench for rtc_bus_arbiter: directed write/read/arbitration/reset
// scenarios followed by random request traffic with per-cycle invariants.
module tb_rtc_bus_arbiter;

  localparam int N_REQ = 4;
  localparam int TA    = 4;
  localparam int TH    = 2;
  localparam int TD    = 6;
  localparam int TR    = 2;
  localparam int D0    = TA + TH;
  localparam int D1    = TA + TH + TD;
  localparam int TOT   = TA + TH + TD + TR;

  typedef struct {
    int         idx;
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rd;
    int         expGnt;
    int         raiseCyc;
  } ent_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N_REQ-1:0]     req;
  logic [N_REQ-1:0]     we;
  logic [8*N_REQ-1:0]   addr;
  logic [8*N_REQ-1:0]   wdata;
  logic [N_REQ-1:0]     gnt;
  logic [N_REQ-1:0]     done;
  logic [7:0]           rdata;
  logic                 cs_n, as_n, rd_n, wr_n;
  logic [7:0]           ad_out;
  logic                 ad_oe;
  logic [7:0]           ad_in;

  ent_t sb[$];
  int   cyc = 0;
  int   testsRun = 0;
  int   testsFailed = 0;

  int               inTxn = 0;
  int               gStart = 0;
  int               lastWinM = N_REQ - 1;
  int               expIdx;
  int               cand;
  int               pos;
  int               off;
  ent_t             cur;
  logic [N_REQ-1:0] prevGnt = '0;
  logic [N_REQ-1:0] prevDone = '0;
  logic [7:0]       lastRd = 8'h00;
  bit               randomOn = 1'b0;

  rtc_bus_arbiter #(
    .N_REQ (N_REQ),
    .T_ADDR(TA),
    .T_HOLD(TH),
    .T_DATA(TD),
    .T_REC (TR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .gnt   (gnt),
    .done  (done),
    .rdata (rdata),
    .cs_n  (cs_n),
    .as_n  (as_n),
    .rd_n  (rd_n),
    .wr_n  (wr_n),
    .ad_out(ad_out),
    .ad_oe (ad_oe),
    .ad_in (ad_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Raise a request and record what the bus should show when it is served.
  task automatic applyStimulus(input int idx, input bit wr, input logic [7:0] a,
                               input logic [7:0] d, input logic [7:0] rd, input int expGnt);
    ent_t e;
    e.idx = idx; e.wr = wr; e.a = a; e.d = d; e.rd = rd;
    e.expGnt = expGnt; e.raiseCyc = cyc;
    we[idx]          = wr;
    addr[8*idx +: 8]  = a;
    wdata[8*idx +: 8] = d;
    req[idx]         = 1'b1;
    sb.push_back(e);
  endtask

  task automatic nextCycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      nextCycle(1);
      k++;
    end
    if (sb.size() != 0) checkOutput("idle_timeout", sb.size(), 0);
  endtask

  // Monitor: checks pin timing against the transaction model, drives ad_in,
  // plays the requester side of the done handshake.
  initial begin
    ad_in = 8'hEE;
    forever begin
      @(negedge clk);
      if (!reset) begin
        inTxn    = 0;
        lastWinM = N_REQ - 1;
        prevGnt  = '0;
        prevDone = '0;
        lastRd   = 8'h00;
        ad_in    = 8'hEE;
      end else begin
        checkOutput("as_data_overlap", 32'(!as_n && (!rd_n || !wr_n)), 0);
        checkOutput("rd_wr_overlap", 32'(!rd_n && !wr_n), 0);
        checkOutput("oe_during_read", 32'(!rd_n && ad_oe), 0);
        checkOutput("gnt_onehot", 32'($onehot0(gnt)), 1);
        checkOutput("done_one_cycle", 32'((done != 0) && (prevDone != 0)), 0);
        if (inTxn == 0 && prevGnt == '0 && gnt != '0) begin
          expIdx = -1;
          for (int k = 1; k <= N_REQ; k++) begin
            cand = (lastWinM + k) % N_REQ;
            if (expIdx < 0)
              foreach (sb[j]) if (sb[j].idx == cand && sb[j].raiseCyc < cyc) expIdx = cand;
          end
          checkOutput("rr_winner", 32'(gnt), (expIdx < 0) ? 32'd0 : (32'd1 << expIdx));
          if (expIdx >= 0) begin
            foreach (sb[j]) if (sb[j].idx == expIdx) cur = sb[j];
            if (cur.expGnt >= 0) checkOutput("gnt_cycle", cyc, cur.expGnt);
            inTxn  = 1;
            gStart = cyc;
          end
        end
        if (inTxn != 0) begin
          off = cyc - gStart;
          if (off < TOT) begin
            checkOutput("gnt_hold", 32'(gnt), 32'd1 << cur.idx);
            checkOutput("done_early", 32'(done), 0);
            checkOutput("as_n", 32'(as_n), (off < TA) ? 0 : 1);
            checkOutput("cs_n", 32'(cs_n), (off >= D0 && off < D1) ? 0 : 1);
            checkOutput("wr_n", 32'(wr_n), (cur.wr && off >= D0 && off < D1) ? 0 : 1);
            checkOutput("rd_n", 32'(rd_n), (!cur.wr && off >= D0 && off < D1) ? 0 : 1);
            checkOutput("ad_oe", 32'(ad_oe), (off < D0 || (cur.wr && off < D1)) ? 1 : 0);
            if (off < D0) checkOutput("ad_out_addr", 32'(ad_out), 32'(cur.a));
            else if (cur.wr && off < D1) checkOutput("ad_out_wdata", 32'(ad_out), 32'(cur.d));
            ad_in = (!cur.wr && off >= D0 && off < D1) ? cur.rd : 8'hEE;
          end else begin
            checkOutput("done_pulse", 32'(done), 32'd1 << cur.idx);
            checkOutput("gnt_cleared", 32'(gnt), 0);
            if (!cur.wr) lastRd = cur.rd;
            checkOutput("rdata", 32'(rdata), 32'(lastRd));
            lastWinM = cur.idx;
            req[cur.idx] = 1'b0;
            pos = -1;
            foreach (sb[j]) if (pos < 0 && sb[j].idx == cur.idx) pos = j;
            if (pos >= 0) sb.delete(pos);
            inTxn = 0;
            ad_in = 8'hEE;
          end
        end else if (done != '0) begin
          checkOutput("spurious_done", 32'(done), 0);
        end
        prevGnt  = gnt;
        prevDone = done;
      end
    end
  end

  // Random traffic: idle requesters occasionally raise a new request.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randomOn && reset) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (!req[i] && $urandom_range(0, 7) == 0)
            applyStimulus(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    reset = 1'b0;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    nextCycle(3);
    checkOutput("rst_gnt", 32'(gnt), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_rdata", 32'(rdata), 0);
    checkOutput("rst_strobes", 32'({cs_n, as_n, rd_n, wr_n}), 32'hF);
    checkOutput("rst_oe", 32'(ad_oe), 0);
    checkOutput("rst_ad_out", 32'(ad_out), 0);
    reset = 1'b1;
    nextCycle(1);

    // Single write; requester inputs change after grant and must be ignored.
    c = cyc;
    applyStimulus(0, 1'b1, 8'h0A, 8'h20, 8'h00, c + 1);
    nextCycle(3);
    addr[7:0]  = 8'hFF;
    wdata[7:0] = 8'hFF;
    we[0]      = 1'b0;
    waitIdle(100);

    // Single read from requester 1.
    c = cyc;
    applyStimulus(1, 1'b0, 8'h04, 8'h00, 8'h37, c + 1);
    waitIdle(100);
    nextCycle(3);
    checkOutput("rdata_held", 32'(rdata), 32'h37);

    // Reset in the middle of a write's DATA phase.
    c = cyc;
    applyStimulus(0, 1'b1, 8'h0B, 8'h55, 8'h00, c + 1);
    nextCycle(9);
    reset = 1'b0;
    sb.delete();
    req = '0;
    #1;
    checkOutput("abort_gnt", 32'(gnt), 0);
    checkOutput("abort_strobes", 32'({cs_n, as_n, rd_n, wr_n}), 32'hF);
    checkOutput("abort_oe", 32'(ad_oe), 0);
    checkOutput("abort_rdata", 32'(rdata), 0);
    nextCycle(3);
    reset = 1'b1;
    nextCycle(1);

    // All four at once: 0,1,2,3 each 16 cycles apart; then 0 and 2 again.
    c = cyc;
    applyStimulus(0, 1'b1, 8'h00, 8'h11, 8'h00, c + 1);
    applyStimulus(1, 1'b0, 8'h02, 8'h00, 8'hA5, c + 17);
    applyStimulus(2, 1'b1, 8'h07, 8'h33, 8'h00, c + 33);
    applyStimulus(3, 1'b0, 8'h09, 8'h00, 8'h5A, c + 49);
    nextCycle(52);
    applyStimulus(0, 1'b0, 8'h0C, 8'h00, 8'hC3, c + 65);
    applyStimulus(2, 1'b1, 8'h08, 8'h12, 8'h00, c + 81);
    waitIdle(200);

    // Late request from 2 during 0's DATA phase.
    c = cyc;
    applyStimulus(0, 1'b1, 8'h06, 8'h03, 8'h00, c + 1);
    nextCycle(8);
    applyStimulus(2, 1'b0, 8'h0D, 8'h00, 8'h80, c + 17);
    waitIdle(100);

    // Random traffic.
    randomOn = 1'b1;
    nextCycle(10000);
    randomOn = 1'b0;
    waitIdle(500);
    nextCycle(4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/rtc_bus_arbiter.md
# rtc_bus_arbiter

Shares the RTC chip's multiplexed address/data bus between up to `N_REQ` requesters: init sequencer, date writer, time writer, timer writer, periodic reader. Grants the bus round-robin, runs one complete strobed bus transaction per grant, returns read data, and pulses `done` to the granted requester. Sits between the RTC-facing requesters and the top-level pins (`cs_n`, `as_n`, `rd_n`, `wr_n`, tri-stated `AD`).

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `T_ADDR`, 4: cycles with `as_n` low (address phase), 1..63.
- `T_HOLD`, 2: cycles of address hold after `as_n` rises, 1..63.
- `T_DATA`, 6: cycles with `rd_n`/`wr_n` low, 1..63.
- `T_REC`, 2: recovery cycles, all strobes high, 1..63.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  request per requester; held high until its `done`.
- `we`  in  N_REQ  1 = write, 0 = read, per requester.
- `addr`  in  8*N_REQ  RTC register address, requester i at [8i+7:8i].
- `wdata`  in  8*N_REQ  write data, same packing.
- `gnt`  out  N_REQ  one-hot grant, high for whole transaction.
- `done`  out  N_REQ  one-cycle completion pulse to granted requester.
- `rdata`  out  8  last read data; valid from `done` until next read's `done`.
- `cs_n`, `as_n`, `rd_n`, `wr_n`  out  1 each  RTC strobes, active-low.
- `ad_out`  out  8  bus drive value.
- `ad_oe`  out  1  bus output enable (tri-state control at top level).
- `ad_in`  in  8  bus sample from pad.

## Operation
- States: IDLE, ADDR, HOLD, DATA, REC, DONE.
- IDLE: all strobes high, `ad_oe`=0, `ad_out`=0. If any `req` set, choose winner round-robin: search starts at (last_winner+1) mod N_REQ, wraps. Latch winner's `addr`/`wdata`/`we`; set `gnt` one-hot; go ADDR.
- ADDR (T_ADDR cycles): `as_n`=0, `cs_n`=1, `ad_oe`=1, `ad_out`=latched addr.
- HOLD (T_HOLD): `as_n`=1, address still driven.
- DATA (T_DATA): `cs_n`=0. Write: `wr_n`=0, `ad_oe`=1, `ad_out`=latched wdata. Read: `rd_n`=0, `ad_oe`=0; `ad_in` captured into `rdata` on last DATA cycle.
- REC (T_REC): all strobes high, `ad_oe`=0.
- DONE (1 cycle): `done[winner]`=1, `gnt` cleared, last_winner updated; no arbitration this cycle; go IDLE.
- Single phase counter, 6 bits, cleared at each state entry; phase ends when counter = T_x−1.
- Requester inputs are ignored outside IDLE (latched copy used); changes mid-transaction have no effect.
- `req` of a non-granted requester is never lost; it waits.

## Timing
- Reset (asynchronous, `reset`=0): state IDLE, `gnt`=0, `done`=0, `rdata`=0, `cs_n`=`as_n`=`rd_n`=`wr_n`=1, `ad_oe`=0, `ad_out`=0, last_winner=N_REQ−1 (req 0 wins first). Reset mid-transaction aborts immediately; no `done` issued.
- `req` sampled high in IDLE at edge k → `gnt` and `as_n`=0 from cycle k+1.
- Transaction length from `gnt` rise to `done` pulse: T_ADDR+T_HOLD+T_DATA+T_REC cycles; `done` in the next cycle. Defaults: 14 cycles, `done` in cycle 15.
- Minimum gap between `done` and next `gnt`: 2 cycles (DONE, IDLE).
- Requester must drop `req` in the cycle after `done`; a `req` still high in IDLE is a new request.
- Strobes never overlap: `as_n` and (`rd_n` or `wr_n`) never low simultaneously; `rd_n` and `wr_n` never both low; `ad_oe`=0 whenever `rd_n`=0.

## Structure
- Shared package `rtc_pkg`: state enum, strobe-idle constant (cs_n/as_n/rd_n/wr_n = 1111), default timing constants, RTC register address constants.
- One natural sub-module: `rr_picker` (combinational round-robin one-hot select from `req` and last_winner). Rest stays flat.

## Test plan
- Reset then `req`=0001, `we[0]`=1, addr 0x0A, wdata 0x20 → `gnt`=0001 next cycle, `ad_out`=0x0A for 6 cycles with `as_n` low first 4, `wr_n` low 6 cycles with `ad_out`=0x20, `done[0]` at cycle 15.
- Read: `req`=0010, `we`=0, addr 0x04, `ad_in`=0x37 during DATA → `ad_oe`=0 while `rd_n` low, `rdata`=0x37 when `done[1]` pulses.
- All four requests at once, held → grants in order 0,1,2,3, each 14 cycles, 2-cycle gaps; then requester 0 re-requests and wins after 3.
- Requester 2 raises `req` during requester 0's DATA phase → no glitch on `gnt`; requester 2 granted 2 cycles after `done[0]`.
- `reset` asserted mid-DATA of a write → strobes high, `ad_oe`=0, `gnt`=0 immediately, no `done`; after release, req 0 wins first.
- Assertion bench: random req/we traffic 10k cycles → strobe-overlap, one-hot `gnt`, one-cycle `done` invariants never violated.
